// File: rtl/sccb_master.sv
// -----------------------------------------------------------------------------
// sccb_master
//
// Write-only SCCB (I2C-compatible) master for camera register setup.  One
// transfer sends four bytes: device address+W, register address high,
// register address low and the data byte, framed by START and STOP.
//
// Every bus event is paced by a quarter-bit tick.  Each START condition,
// each bit slot (8 data slots + 1 ack slot per byte) and the STOP condition
// lasts four ticks, numbered phase 0..3.
//
// Parameters
//   CLK_DIV      clk_25M cycles per quarter-bit tick (default 63, ~99 kHz SCL)
//
// Ports
//   clk_25M      single clock, all logic on its rising edge
//   camera_rstn  synchronous active-low reset
//   start        level request; a transfer is accepted from IDLE while high
//   i2c_data     {dev_addr_w, reg_hi, reg_lo, data}, latched on acceptance
//   tr_end       transfer finished; held until start is seen low
//   ack          1 = every byte acknowledged; valid while tr_end = 1
//   busy         transfer in progress (START through STOP)
//   i2c_sclk     SCL, push-pull
//   i2c_sdat     SDA, open-drain: drives 0 or high-Z, never 1
//   fsm_state    current controller state, for observation only
//
// Handshake: start is a level.  A transfer is accepted on any rising edge
// where the controller is IDLE and start = 1.  Once finished the controller
// parks in DONE with tr_end = 1 until start is sampled low; only then does
// it return to IDLE, so a start held high cannot retrigger.
//
// Build option
//   SCCB_ACK_CHECK_EN  when defined, the ack slot of every byte is sampled on
//                      phase 2; a high sample aborts the transfer (STOP right
//                      after that slot) and reports ack = 0.  When undefined
//                      the ack slot is an SCCB don't-care: nothing is sampled,
//                      all four bytes are always sent and ack = 1 at the end.
// -----------------------------------------------------------------------------
module sccb_master #(
   parameter int CLK_DIV = 63
) (
   input  logic        clk_25M,
   input  logic        camera_rstn,
   input  logic        start,
   input  logic [31:0] i2c_data,
   output logic        tr_end,
   output logic        ack,
   output logic        busy,
   output logic        i2c_sclk,
   inout  wire         i2c_sdat,
   output logic [2:0]  fsm_state
);

   localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      BIT   = 3'd2,
      STOP  = 3'd3,
      DONE  = 3'd4
   } state_t;

   state_t        state;
   logic [DW-1:0] div_cnt;    // clocks within the current tick period
   logic          tick;       // one-clock pulse every CLK_DIV clocks
   logic [1:0]    phase;      // quarter of the current slot / condition
   logic [2:0]    bit_idx;    // data bit being sent, 7 (MSB) down to 0
   logic [1:0]    byte_idx;   // byte being sent, 0..3
   logic          ack_slot;   // current slot is the ninth (ack) slot
   logic [31:0]   shreg;      // latched frame; bit 31 is the next bit out
   logic          ack_ok;     // no NACK seen so far in this transfer
   logic          sda_low;    // 1 = pull SDA low, 0 = release

   assign tick      = (div_cnt == DW'(CLK_DIV - 1));
   assign fsm_state = state;

   // Open-drain: the only driven level is 0; a 1 comes from the pull-up.
   assign i2c_sdat  = sda_low ? 1'b0 : 1'bz;

   // Single FSM block.  Outputs are registered and updated on the same edge
   // that moves the FSM into the phase they belong to, so SCL/SDA always
   // reflect the current phase with no extra cycle of lag.
   always_ff @(posedge clk_25M) begin
      if (!camera_rstn) begin
         state    <= IDLE;
         div_cnt  <= '0;
         phase    <= 2'd0;
         bit_idx  <= 3'd0;
         byte_idx <= 2'd0;
         ack_slot <= 1'b0;
         shreg    <= 32'd0;
         ack_ok   <= 1'b0;
         sda_low  <= 1'b0;
         i2c_sclk <= 1'b1;
         tr_end   <= 1'b0;
         ack      <= 1'b0;
         busy     <= 1'b0;
      end else begin
         // Free-running divider; restarted below when a transfer is
         // accepted so the first tick lands exactly CLK_DIV clocks later.
         div_cnt <= tick ? '0 : div_cnt + DW'(1);

         case (state)
            IDLE: begin
               i2c_sclk <= 1'b1;
               sda_low  <= 1'b0;
               busy     <= 1'b0;
               if (start) begin
                  shreg    <= i2c_data;
                  busy     <= 1'b1;
                  ack_ok   <= 1'b1;
                  div_cnt  <= '0;
                  phase    <= 2'd0;
                  bit_idx  <= 3'd7;
                  byte_idx <= 2'd0;
                  ack_slot <= 1'b0;
                  state    <= START;
               end
            end

            // START: phases 0-1 bus idle, phase 2 SDA falls with SCL high,
            // phase 3 SCL falls.
            START: begin
               if (tick) begin
                  phase <= phase + 2'd1;
                  case (phase)
                     2'd1: sda_low  <= 1'b1;
                     2'd2: i2c_sclk <= 1'b0;
                     2'd3: begin
                        state    <= BIT;
                        bit_idx  <= 3'd7;
                        byte_idx <= 2'd0;
                        ack_slot <= 1'b0;
                        // First data bit goes out at phase 0 of slot 0.
                        sda_low  <= ~shreg[31];
                     end
                     default: ;
                  endcase
               end
            end

            // BIT: SDA only changes when entering phase 0 (SCL low);
            // SCL is high for phases 1-2 and falls again at phase 3.
            BIT: begin
               if (tick) begin
                  phase <= phase + 2'd1;
                  case (phase)
                     2'd0: i2c_sclk <= 1'b1;
                     2'd2: begin
                        i2c_sclk <= 1'b0;
`ifdef SCCB_ACK_CHECK_EN
                        // Last clock of phase 2: SCL has been high for a
                        // full tick, the slave's answer is settled.
                        if (ack_slot && i2c_sdat) begin
                           ack_ok <= 1'b0;
                        end
`endif
                     end
                     2'd3: begin
                        if (!ack_slot) begin
                           shreg <= {shreg[30:0], 1'b0};
                           if (bit_idx == 3'd0) begin
                              // Hand SDA to the slave for the ack slot.
                              ack_slot <= 1'b1;
                              sda_low  <= 1'b0;
                           end else begin
                              bit_idx <= bit_idx - 3'd1;
                              // shreg[30] becomes the MSB after this shift.
                              sda_low <= ~shreg[30];
                           end
                        end else begin
                           ack_slot <= 1'b0;
                           // ack_ok can only drop when NACK checking is built in.
                           if (byte_idx == 2'd3 || !ack_ok) begin
                              state   <= STOP;
                              sda_low <= 1'b1;
                           end else begin
                              byte_idx <= byte_idx + 2'd1;
                              bit_idx  <= 3'd7;
                              // Eight shifts have brought the next byte's
                              // MSB to bit 31.
                              sda_low  <= ~shreg[31];
                           end
                        end
                     end
                     default: ;
                  endcase
               end
            end

            // STOP: phase 0 SCL low with SDA low, phases 1-2 SCL high,
            // phase 3 SDA released while SCL is high.
            STOP: begin
               if (tick) begin
                  phase <= phase + 2'd1;
                  case (phase)
                     2'd0: i2c_sclk <= 1'b1;
                     2'd2: sda_low  <= 1'b0;
                     2'd3: begin
                        state  <= DONE;
                        tr_end <= 1'b1;
                        ack    <= ack_ok;
                        busy   <= 1'b0;
                     end
                     default: ;
                  endcase
               end
            end

            DONE: begin
               if (!start) begin
                  state  <= IDLE;
                  tr_end <= 1'b0;
                  ack    <= 1'b0;
               end
            end

            default: begin
               state    <= IDLE;
               i2c_sclk <= 1'b1;
               sda_low  <= 1'b0;
               busy     <= 1'b0;
            end
         endcase
      end
   end

endmodule
